// File: rtl/laser_strobe_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// laser_strobe_pkg
// Shared definitions for the laser strobe sequencer:
//   - Avalon word addresses of the register map
//   - CTRL / STATUS bit positions
//   - frame state encoding (3 bits, visible in STATUS[6:4])
//   - helper that picks the next enabled laser channel (round-robin)
// -----------------------------------------------------------------------------
package laser_strobe_pkg;

   localparam logic [2:0] ADDR_CTRL      = 3'd0;
   localparam logic [2:0] ADDR_STATUS    = 3'd1;
   localparam logic [2:0] ADDR_LASER_DLY = 3'd2;
   localparam logic [2:0] ADDR_DLP_W     = 3'd3;
   localparam logic [2:0] ADDR_XTRIG_DLY = 3'd4;
   localparam logic [2:0] ADDR_XTRIG_W   = 3'd5;
   localparam logic [2:0] ADDR_HOLD      = 3'd6;
   localparam logic [2:0] ADDR_FRAMES    = 3'd7;

   // Registers 2..7 are plain byte-lane registers; the last one is FRAMES.
   localparam int NUM_CFG   = 6;
   localparam int NUM_DUR   = 5;
   localparam int FRAME_W   = 16;

   localparam int CTRL_START_BIT    = 0;
   localparam int CTRL_ABORT_BIT    = 1;
   localparam int CTRL_MASK_LSB     = 8;

   localparam int STAT_BUSY_BIT     = 0;
   localparam int STAT_DONE_BIT     = 1;
   localparam int STAT_MASK_ERR_BIT = 2;
   localparam int STAT_STATE_LSB    = 4;
   localparam int STAT_FRAMES_LSB   = 16;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_DLP   = 3'd2,
      ST_XWAIT = 3'd3,
      ST_XTRIG = 3'd4,
      ST_HOLD  = 3'd5,
      ST_NEXT  = 3'd6
   } seq_state_t;

   // First set bit of mask strictly after cur, wrapping at n_ch.
   // Calling with cur = n_ch-1 yields the lowest set bit.
   // Returns cur unchanged when the mask is empty.
   function automatic logic [2:0] next_set_ch(input logic [7:0]  mask,
                                              input logic [2:0]  cur,
                                              input int unsigned n_ch);
      logic [2:0]  res;
      logic        found;
      int unsigned idx;
      res   = cur;
      found = 1'b0;
      for (int unsigned i = 1; i <= 8; i++) begin
         idx = (32'(cur) + i) % n_ch;
         if (!found && (i <= n_ch) && mask[idx[2:0]]) begin
            res   = idx[2:0];
            found = 1'b1;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/laser_strobe_sequencer_if.sv
// -----------------------------------------------------------------------------
// laser_strobe_sequencer_if
// Avalon-MM slave bus of the laser strobe sequencer.
//   slave_chipselect_n : active-low select, qualifies read/write
//   slave_addr         : word address (8 registers)
//   slave_byteenable   : per-byte write enables
//   slave_read/write   : strobes
//   slave_writedata    : write data
//   slave_readdata     : registered read data (valid one cycle after read)
// Modports: master (bus host side), slave (sequencer side).
// -----------------------------------------------------------------------------
interface laser_strobe_sequencer_if #(
   parameter int DATA_WIDTH = 32
);
   logic                    slave_chipselect_n;
   logic [2:0]              slave_addr;
   logic [DATA_WIDTH/8-1:0] slave_byteenable;
   logic                    slave_read;
   logic                    slave_write;
   logic [DATA_WIDTH-1:0]   slave_writedata;
   logic [DATA_WIDTH-1:0]   slave_readdata;

   modport master (
      output slave_chipselect_n, slave_addr, slave_byteenable,
             slave_read, slave_write, slave_writedata,
      input  slave_readdata
   );

   modport slave (
      input  slave_chipselect_n, slave_addr, slave_byteenable,
             slave_read, slave_write, slave_writedata,
      output slave_readdata
   );
endinterface

// File: rtl/laser_strobe_sequencer_bytelane_reg.sv
// -----------------------------------------------------------------------------
// avmm_bytelane_reg
// Width-parametrised register whose bytes are written independently.
//   slave_clk, slave_reset_n : clock, asynchronous active-low reset
//   wr_en                    : register selected for a write this cycle
//   byteenable               : per-byte enables (last byte may be partial)
//   wdata                    : write data
//   q                        : current register value
// -----------------------------------------------------------------------------
module avmm_bytelane_reg #(
   parameter  int WIDTH     = 16,
   localparam int NUM_BYTES = (WIDTH + 7) / 8
) (
   input  logic                 slave_clk,
   input  logic                 slave_reset_n,
   input  logic                 wr_en,
   input  logic [NUM_BYTES-1:0] byteenable,
   input  logic [WIDTH-1:0]     wdata,
   output logic [WIDTH-1:0]     q
);

   genvar gi;
   generate
      for (gi = 0; gi < NUM_BYTES; gi++) begin : g_byte
         localparam int LO = gi * 8;
         localparam int HI = ((LO + 8) > WIDTH) ? (WIDTH - 1) : (LO + 7);

         logic [HI-LO:0] byte_reg;

         always_ff @(posedge slave_clk or negedge slave_reset_n) begin
            if (!slave_reset_n) begin
               byte_reg <= '0;
            end else if (wr_en && byteenable[gi]) begin
               byte_reg <= wdata[HI:LO];
            end
         end

         assign q[HI:LO] = byte_reg;
      end
   endgenerate

endmodule

// File: rtl/laser_strobe_sequencer.sv
// -----------------------------------------------------------------------------
// laser_strobe_sequencer
// Avalon-MM programmed illumination/trigger sequencer. Each frame walks
// SETUP -> DLP -> XWAIT -> XTRIG -> HOLD -> NEXT, driving one laser channel
// (round-robin over the channel mask), the DLP enable and the sensor trigger.
//   slave_clk, slave_reset_n : clock, asynchronous active-low reset
//   avs                      : Avalon-MM slave bus (register access)
//   laser_en_o               : one-hot laser enables
//   dlp_en_o                 : DLP enable
//   xtrig_o                  : sensor trigger
//   irq_o                    : level interrupt, mirrors STATUS.done
// -----------------------------------------------------------------------------
module laser_strobe_sequencer
   import laser_strobe_pkg::*;
#(
   parameter int NUM_CH     = 2,
   parameter int CNT_WIDTH  = 16,
   parameter int TICK_DIV   = 50,
   parameter int DATA_WIDTH = 32
) (
   input  logic                 slave_clk,
   input  logic                 slave_reset_n,
   laser_strobe_sequencer_if.slave avs,
   output logic [NUM_CH-1:0]    laser_en_o,
   output logic                 dlp_en_o,
   output logic                 xtrig_o,
   output logic                 irq_o
);

   localparam int         PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [7:0] CH_MASK = 8'((1 << NUM_CH) - 1);

   // ---------------- bus decode ----------------
   logic bus_wr, bus_rd, ctrl_wr, status_w1c;
   logic start_req, abort_req;
   logic [7:0] mask_wr_val;

   assign bus_wr     = !avs.slave_chipselect_n && avs.slave_write;
   assign bus_rd     = !avs.slave_chipselect_n && avs.slave_read;
   assign ctrl_wr    = bus_wr && (avs.slave_addr == ADDR_CTRL);
   assign status_w1c = bus_wr && (avs.slave_addr == ADDR_STATUS) && avs.slave_byteenable[0];
   // Abort outranks a start carried in the same write.
   assign abort_req  = ctrl_wr && avs.slave_byteenable[0] && avs.slave_writedata[CTRL_ABORT_BIT];
   assign start_req  = ctrl_wr && avs.slave_byteenable[0] && avs.slave_writedata[CTRL_START_BIT]
                       && !avs.slave_writedata[CTRL_ABORT_BIT];

   logic [7:0] mask_reg;
   // A START may carry its own mask; that mask is the one shadowed.
   assign mask_wr_val = (ctrl_wr && avs.slave_byteenable[1])
                        ? (avs.slave_writedata[CTRL_MASK_LSB +: 8] & CH_MASK) : mask_reg;

   logic unused_bus;
   assign unused_bus = ^{avs.slave_writedata, avs.slave_byteenable};

   // ---------------- timing / frame registers (addresses 2..7) ----------------
   logic [DATA_WIDTH-1:0] cfg_q [NUM_CFG];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CFG; gi++) begin : g_cfg
         localparam int W = (gi == NUM_CFG - 1) ? FRAME_W : CNT_WIDTH;
         logic [W-1:0] cfg_val;

         avmm_bytelane_reg #(.WIDTH(W)) u_reg (
            .slave_clk     (slave_clk),
            .slave_reset_n (slave_reset_n),
            .wr_en         (bus_wr && (avs.slave_addr == 3'(gi + 2))),
            .byteenable    (avs.slave_byteenable[(W+7)/8-1:0]),
            .wdata         (avs.slave_writedata[W-1:0]),
            .q             (cfg_val)
         );

         assign cfg_q[gi] = DATA_WIDTH'(cfg_val);
      end
   endgenerate

   // ---------------- state ----------------
   seq_state_t            state_reg, state_next;
   logic [2:0]            ch_reg, ch_next;
   logic [PW-1:0]         presc_reg;
   logic [CNT_WIDTH-1:0]  tick_cnt_reg;
   logic [FRAME_W-1:0]    frame_cnt_reg;
   logic [CNT_WIDTH-1:0]  dur_shadow_reg [NUM_DUR];
   logic [FRAME_W-1:0]    frames_shadow_reg;
   logic [7:0]            mask_shadow_reg;
   logic                  done_reg, mask_err_reg;
   logic [NUM_CH-1:0]     laser_reg, laser_next;
   logic                  dlp_reg, xtrig_reg;
   logic [DATA_WIDTH-1:0] readdata_reg, rd_mux;

   logic                  start_accept, mask_reject, completion;
   logic [CNT_WIDTH-1:0]  dur_cur, dur_last;
   logic                  state_done;
   logic [7:0]            mask_reload;

   assign start_accept = start_req && (state_reg == ST_IDLE) && (mask_wr_val != 8'd0);
   assign mask_reject  = start_req && (state_reg == ST_IDLE) && (mask_wr_val == 8'd0);
   // An empty mask written mid-run keeps the previous rotation alive.
   assign mask_reload  = (mask_reg != 8'd0) ? mask_reg : mask_shadow_reg;

   always_comb begin
      dur_cur = '0;
      case (state_reg)
         ST_SETUP: dur_cur = dur_shadow_reg[0];
         ST_DLP:   dur_cur = dur_shadow_reg[1];
         ST_XWAIT: dur_cur = dur_shadow_reg[2];
         ST_XTRIG: dur_cur = dur_shadow_reg[3];
         ST_HOLD:  dur_cur = dur_shadow_reg[4];
         default:  dur_cur = '0;
      endcase
   end

   // A zero duration still lasts one tick.
   assign dur_last   = (dur_cur == '0) ? '0 : (dur_cur - 1'b1);
   assign state_done = (presc_reg == PW'(TICK_DIV - 1)) && (tick_cnt_reg == dur_last);

   always_comb begin
      state_next = state_reg;
      ch_next    = ch_reg;
      case (state_reg)
         ST_IDLE: if (start_accept) begin
            state_next = ST_SETUP;
            ch_next    = next_set_ch(mask_wr_val, 3'(NUM_CH - 1), NUM_CH);
         end
         ST_SETUP: if (state_done) state_next = ST_DLP;
         ST_DLP:   if (state_done) state_next = ST_XWAIT;
         ST_XWAIT: if (state_done) state_next = ST_XTRIG;
         ST_XTRIG: if (state_done) state_next = ST_HOLD;
         ST_HOLD:  if (state_done) state_next = ST_NEXT;
         ST_NEXT: begin
            if ((frames_shadow_reg != '0) && (frame_cnt_reg == frames_shadow_reg)) begin
               state_next = ST_IDLE;
            end else begin
               state_next = ST_SETUP;
               ch_next    = next_set_ch(mask_reload, ch_reg, NUM_CH);
            end
         end
         default: state_next = ST_IDLE;
      endcase
      if (abort_req) state_next = ST_IDLE;

      laser_next = '0;
      if ((state_next != ST_IDLE) && (state_next != ST_NEXT)) begin
         laser_next = NUM_CH'(1) << ch_next;
      end
   end

   assign completion = (state_reg == ST_NEXT) && (state_next == ST_IDLE) && !abort_req;

   always_comb begin
      rd_mux = '0;
      if (avs.slave_addr == ADDR_CTRL) begin
         rd_mux[CTRL_MASK_LSB +: 8] = mask_reg;
      end else if (avs.slave_addr == ADDR_STATUS) begin
         rd_mux[STAT_BUSY_BIT]                = (state_reg != ST_IDLE);
         rd_mux[STAT_DONE_BIT]                = done_reg;
         rd_mux[STAT_MASK_ERR_BIT]            = mask_err_reg;
         rd_mux[STAT_STATE_LSB +: 3]          = state_reg;
         rd_mux[STAT_FRAMES_LSB +: FRAME_W]   = frame_cnt_reg;
      end else begin
         for (int i = 0; i < NUM_CFG; i++) begin
            if (avs.slave_addr == 3'(i + 2)) rd_mux = cfg_q[i];
         end
      end
   end

   always_ff @(posedge slave_clk or negedge slave_reset_n) begin
      if (!slave_reset_n) begin
         state_reg         <= ST_IDLE;
         ch_reg            <= '0;
         presc_reg         <= '0;
         tick_cnt_reg      <= '0;
         frame_cnt_reg     <= '0;
         for (int i = 0; i < NUM_DUR; i++) dur_shadow_reg[i] <= '0;
         frames_shadow_reg <= '0;
         mask_shadow_reg   <= '0;
         mask_reg          <= '0;
         done_reg          <= 1'b0;
         mask_err_reg      <= 1'b0;
         laser_reg         <= '0;
         dlp_reg           <= 1'b0;
         xtrig_reg         <= 1'b0;
         readdata_reg      <= '0;
      end else begin
         state_reg <= state_next;
         ch_reg    <= ch_next;
         laser_reg <= laser_next;
         dlp_reg   <= (state_next == ST_DLP);
         xtrig_reg <= (state_next == ST_XTRIG);

         // Prescaler and tick counter restart on every state entry.
         if ((state_next != state_reg) || (state_reg == ST_IDLE) || (state_reg == ST_NEXT)) begin
            presc_reg    <= '0;
            tick_cnt_reg <= '0;
         end else if (presc_reg == PW'(TICK_DIV - 1)) begin
            presc_reg    <= '0;
            tick_cnt_reg <= tick_cnt_reg + 1'b1;
         end else begin
            presc_reg <= presc_reg + 1'b1;
         end

         if (start_accept) begin
            frame_cnt_reg <= '0;
         end else if ((state_reg == ST_HOLD) && (state_next == ST_NEXT) && (frame_cnt_reg != '1)) begin
            frame_cnt_reg <= frame_cnt_reg + 1'b1;
         end

         if (start_accept || ((state_reg == ST_NEXT) && (state_next == ST_SETUP))) begin
            for (int i = 0; i < NUM_DUR; i++) dur_shadow_reg[i] <= cfg_q[i][CNT_WIDTH-1:0];
            frames_shadow_reg <= cfg_q[NUM_CFG-1][FRAME_W-1:0];
            mask_shadow_reg   <= start_accept ? mask_wr_val : mask_reload;
         end

         if (ctrl_wr && avs.slave_byteenable[1]) mask_reg <= mask_wr_val;

         if (completion) begin
            done_reg <= 1'b1;
         end else if (status_w1c && avs.slave_writedata[STAT_DONE_BIT]) begin
            done_reg <= 1'b0;
         end

         if (mask_reject) begin
            mask_err_reg <= 1'b1;
         end else if (status_w1c && avs.slave_writedata[STAT_MASK_ERR_BIT]) begin
            mask_err_reg <= 1'b0;
         end

         if (bus_rd) readdata_reg <= rd_mux;
      end
   end

   assign laser_en_o         = laser_reg;
   assign dlp_en_o           = dlp_reg;
   assign xtrig_o            = xtrig_reg;
   assign irq_o              = done_reg;
   assign avs.slave_readdata = readdata_reg;

endmodule

// File: tb/tb_laser_strobe_sequencer.sv
// -----------------------------------------------------------------------------
// tb_laser_strobe_sequencer
// Self-checking bench: expected output traces are built per frame from the
// programmed durations and the channel rotation order, then compared cycle by
// cycle against the DUT outputs {irq, laser, dlp, xtrig}.
// -----------------------------------------------------------------------------
module tb_laser_strobe_sequencer;
   import laser_strobe_pkg::*;

   localparam int NUM_CH = 4;
   localparam int TD     = 4;
   localparam int CW     = 16;

   logic              slave_clk = 1'b0;
   logic              slave_reset_n = 1'b0;
   logic [NUM_CH-1:0] laser_en_o;
   logic              dlp_en_o, xtrig_o, irq_o;

   laser_strobe_sequencer_if #(.DATA_WIDTH(32)) avs ();

   laser_strobe_sequencer #(
      .NUM_CH(NUM_CH), .CNT_WIDTH(CW), .TICK_DIV(TD), .DATA_WIDTH(32)
   ) dut (
      .slave_clk     (slave_clk),
      .slave_reset_n (slave_reset_n),
      .avs           (avs.slave),
      .laser_en_o    (laser_en_o),
      .dlp_en_o      (dlp_en_o),
      .xtrig_o       (xtrig_o),
      .irq_o         (irq_o)
   );

   always #5 slave_clk = ~slave_clk;

   int total = 0;
   int bad   = 0;
   logic [6:0] exp_q[$];

   // ---------------- bus tasks ----------------
   task automatic avm_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
      @(negedge slave_clk);
      avs.slave_chipselect_n = 1'b0;
      avs.slave_write        = 1'b1;
      avs.slave_addr         = a;
      avs.slave_writedata    = d;
      avs.slave_byteenable   = be;
      @(posedge slave_clk);
      #1;
      avs.slave_chipselect_n = 1'b1;
      avs.slave_write        = 1'b0;
      $display("wr addr=%0d data=%h be=%b", a, d, be);
   endtask

   task automatic avm_read(input logic [2:0] a, output logic [31:0] d);
      @(negedge slave_clk);
      avs.slave_chipselect_n = 1'b0;
      avs.slave_read         = 1'b1;
      avs.slave_addr         = a;
      @(posedge slave_clk);
      #1;
      d = avs.slave_readdata;
      avs.slave_chipselect_n = 1'b1;
      avs.slave_read         = 1'b0;
      $display("rd addr=%0d data=%h", a, d);
   endtask

   task automatic set_timing(input int l, input int d, input int xd, input int xw,
                             input int h, input int f);
      avm_write(ADDR_LASER_DLY, 32'(l),  4'hF);
      avm_write(ADDR_DLP_W,     32'(d),  4'hF);
      avm_write(ADDR_XTRIG_DLY, 32'(xd), 4'hF);
      avm_write(ADDR_XTRIG_W,   32'(xw), 4'hF);
      avm_write(ADDR_HOLD,      32'(h),  4'hF);
      avm_write(ADDR_FRAMES,    32'(f),  4'hF);
   endtask

   task automatic clear_flags();
      avm_write(ADDR_STATUS, 32'h6, 4'b0001);
   endtask

   // ---------------- reference model ----------------
   function automatic int ticks(input int n);
      return TD * ((n == 0) ? 1 : n);
   endfunction

   task automatic push_seg(input logic [6:0] v, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(v);
   endtask

   // One frame: five timed phases with the laser on, then one all-low cycle.
   task automatic add_frame(input int ch, input int l, input int d, input int xd,
                            input int xw, input int h);
      logic [3:0] oh;
      oh = 4'(1 << ch);
      push_seg({1'b0, oh, 1'b0, 1'b0}, ticks(l));
      push_seg({1'b0, oh, 1'b1, 1'b0}, ticks(d));
      push_seg({1'b0, oh, 1'b0, 1'b0}, ticks(xd));
      push_seg({1'b0, oh, 1'b0, 1'b1}, ticks(xw));
      push_seg({1'b0, oh, 1'b0, 1'b0}, ticks(h));
      push_seg(7'b0, 1);
   endtask

   task automatic build_run(input logic [7:0] mask, input int l, input int d, input int xd,
                            input int xw, input int h, input int frames);
      int chans[$];
      for (int c = 0; c < NUM_CH; c++) if (mask[c]) chans.push_back(c);
      for (int f = 0; f < frames; f++) add_frame(chans[f % chans.size()], l, d, xd, xw, h);
      push_seg(7'b1000000, 4);   // idle with irq raised
   endtask

   // Issues START, then compares every cycle of exp_q; optional write mid-run.
   task automatic run_trace(input string name, input logic [7:0] mask, input int mid_idx,
                            input logic [2:0] mid_a, input logic [31:0] mid_d);
      int         bad_at;
      logic [6:0] obs, got_v, exp_v;
      bad_at = -1;
      got_v  = '0;
      exp_v  = '0;
      avm_write(ADDR_CTRL, {16'h0, mask, 8'h01}, 4'b0011);
      for (int i = 0; i < exp_q.size(); i++) begin
         obs = {irq_o, laser_en_o, dlp_en_o, xtrig_o};
         if ((obs !== exp_q[i]) && (bad_at < 0)) begin
            bad_at = i;
            got_v  = obs;
            exp_v  = exp_q[i];
         end
         if (i == mid_idx) avm_write(mid_a, mid_d, 4'hF);
         else begin
            @(posedge slave_clk);
            #1;
         end
      end
      total++;
      if (bad_at >= 0) begin
         bad++;
         $display("FAIL %s trace cycle %0d: got %b expected %b", name, bad_at, got_v, exp_v);
      end else begin
         $display("ok %s trace %0d cycles", name, exp_q.size());
      end
      exp_q.delete();
   endtask

   task automatic expect_status(input string name, input logic [31:0] keep, input logic [31:0] expv);
      logic [31:0] r;
      avm_read(ADDR_STATUS, r);
      total++;
      if ((r & keep) !== expv) begin
         bad++;
         $display("FAIL %s status: got %h expected %h", name, r & keep, expv);
      end
   endtask

   task automatic check_all_zero_regs(input string name);
      logic [31:0] r;
      for (int a = 0; a < 8; a++) begin
         avm_read(3'(a), r);
         total++;
         if (r !== 32'h0) begin
            bad++;
            $display("FAIL %s reg%0d: got %h expected 00000000", name, a, r);
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      total++;
      if ({irq_o, laser_en_o, dlp_en_o, xtrig_o, avs.slave_readdata} !== '0) begin
         bad++;
         $display("FAIL reset_outputs: got %b/%h expected all 0",
                  {irq_o, laser_en_o, dlp_en_o, xtrig_o}, avs.slave_readdata);
      end
      check_all_zero_regs("reset");
   endtask

   task automatic test_register_rw();
      logic [31:0] model [8];
      logic [31:0] d, r;
      logic [3:0]  be;
      logic [2:0]  a;
      for (int i = 0; i < 8; i++) model[i] = '0;
      for (int n = 0; n < 12; n++) begin
         a  = 3'($urandom_range(2, 7));
         d  = $urandom;
         be = 4'($urandom_range(0, 15));
         avm_write(a, d, be);
         for (int b = 0; b < 4; b++) if (be[b]) model[a][b*8 +: 8] = d[b*8 +: 8];
         model[a] = model[a] & 32'h0000_FFFF;
      end
      for (int i = 2; i < 8; i++) begin
         avm_read(3'(i), r);
         total++;
         if (r !== model[i]) begin
            bad++;
            $display("FAIL regrw reg%0d: got %h expected %h", i, r, model[i]);
         end
      end
      d = $urandom;
      avm_write(ADDR_CTRL, d, 4'b0010);
      avm_read(ADDR_CTRL, r);
      total++;
      if (r !== {16'h0, d[15:8] & 8'h0F, 8'h0}) begin
         bad++;
         $display("FAIL regrw ctrl_mask: got %h expected %h", r, {16'h0, d[15:8] & 8'h0F, 8'h0});
      end
   endtask

   task automatic test_two_frames();
      set_timing(2, 3, 1, 2, 1, 2);
      clear_flags();
      build_run(8'b0101, 2, 3, 1, 2, 1, 2);
      run_trace("two_frames", 8'b0101, -1, 3'd0, 32'h0);
      expect_status("two_frames", 32'hFFFF_FFFF, 32'h0002_0002);
      clear_flags();
      total++;
      if (irq_o !== 1'b0) begin
         bad++;
         $display("FAIL irq_w1c: got %b expected 0", irq_o);
      end
   endtask

   task automatic test_zero_durations();
      set_timing(0, 0, 0, 0, 0, 1);
      clear_flags();
      build_run(8'b1000, 0, 0, 0, 0, 0, 1);   // 5*4 + 1 = 21 active cycles
      run_trace("zero_dur", 8'b1000, -1, 3'd0, 32'h0);
      expect_status("zero_dur", 32'hFFFF_FFFF, 32'h0001_0002);
   endtask

   task automatic test_random_frames();
      int l, d, xd, xw, h, f;
      logic [7:0] m;
      for (int it = 0; it < 3; it++) begin
         l  = $urandom_range(0, 3);
         d  = $urandom_range(0, 3);
         xd = $urandom_range(0, 3);
         xw = $urandom_range(0, 3);
         h  = $urandom_range(0, 3);
         f  = $urandom_range(1, 3);
         m  = 8'($urandom_range(1, 15));
         set_timing(l, d, xd, xw, h, f);
         clear_flags();
         build_run(m, l, d, xd, xw, h, f);
         // A second START early in the first frame must be ignored.
         run_trace("random_busy_start", m, $urandom_range(0, 9), ADDR_CTRL,
                   {16'h0, m, 8'h01});
         expect_status("random_frames", 32'h0000_FFFF, 32'h0000_0002);
      end
   endtask

   task automatic test_midframe_change();
      set_timing(1, 5, 1, 1, 1, 0);
      clear_flags();
      add_frame(0, 1, 5, 1, 1, 1);
      add_frame(1, 1, 9, 1, 1, 1);
      run_trace("midframe_dlp", 8'b0011, 2, ADDR_DLP_W, 32'd9);
      avm_write(ADDR_CTRL, 32'h2, 4'b0001);
      expect_status("midframe_abort", 32'h0000_0077, 32'h0);
   endtask

   task automatic test_abort();
      int   seen;
      int   active;
      set_timing(1, 1, 1, 3, 1, 0);
      clear_flags();
      avm_write(ADDR_CTRL, 32'h0000_0301, 4'b0011);
      seen = 0;
      for (int i = 0; i < 400 && seen == 0; i++) begin
         if (xtrig_o === 1'b1) seen = 1;
         else begin
            @(posedge slave_clk);
            #1;
         end
      end
      total++;
      if (seen == 0) begin
         bad++;
         $display("FAIL abort_wait_xtrig: got no xtrig within 400 cycles, required xtrig high");
         return;
      end
      avm_write(ADDR_CTRL, 32'h0000_0003, 4'b0001);   // abort + start: abort wins
      total++;
      if ({irq_o, laser_en_o, dlp_en_o, xtrig_o} !== 7'b0) begin
         bad++;
         $display("FAIL abort_outputs: got %b expected 0000000",
                  {irq_o, laser_en_o, dlp_en_o, xtrig_o});
      end
      active = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge slave_clk);
         #1;
         if ({irq_o, laser_en_o, dlp_en_o, xtrig_o} !== 7'b0) active++;
      end
      total++;
      if (active !== 0) begin
         bad++;
         $display("FAIL abort_quiet: got %0d active cycles expected 0", active);
      end
      expect_status("abort", 32'h0000_0077, 32'h0);
   endtask

   task automatic test_mask_err();
      int active;
      avm_write(ADDR_CTRL, 32'h0000_0001, 4'b0011);   // START with empty mask
      active = 0;
      for (int i = 0; i < 20; i++) begin
         if ({irq_o, laser_en_o, dlp_en_o, xtrig_o} !== 7'b0) active++;
         @(posedge slave_clk);
         #1;
      end
      total++;
      if (active !== 0) begin
         bad++;
         $display("FAIL mask_err_quiet: got %0d active cycles expected 0", active);
      end
      expect_status("mask_err_set", 32'h0000_0077, 32'h0000_0004);
      avm_write(ADDR_STATUS, 32'h4, 4'b0001);
      expect_status("mask_err_clr", 32'h0000_0077, 32'h0);
   endtask

   task automatic test_reset_during_dlp();
      int seen;
      set_timing(2, 4, 1, 1, 1, 0);
      avm_write(ADDR_CTRL, 32'h0000_0601, 4'b0011);
      seen = 0;
      for (int i = 0; i < 200 && seen == 0; i++) begin
         if (dlp_en_o === 1'b1) seen = 1;
         else begin
            @(posedge slave_clk);
            #1;
         end
      end
      total++;
      if (seen == 0) begin
         bad++;
         $display("FAIL reset_wait_dlp: got no dlp within 200 cycles, required dlp high");
         return;
      end
      #2;
      slave_reset_n = 1'b0;
      #1;
      total++;
      if ({irq_o, laser_en_o, dlp_en_o, xtrig_o, avs.slave_readdata} !== '0) begin
         bad++;
         $display("FAIL reset_async: got %b/%h expected all 0",
                  {irq_o, laser_en_o, dlp_en_o, xtrig_o}, avs.slave_readdata);
      end
      repeat (2) @(negedge slave_clk);
      slave_reset_n = 1'b1;
      check_all_zero_regs("reset_dlp");
   endtask

   initial begin
      avs.slave_chipselect_n = 1'b1;
      avs.slave_read         = 1'b0;
      avs.slave_write        = 1'b0;
      avs.slave_addr         = '0;
      avs.slave_writedata    = '0;
      avs.slave_byteenable   = '0;
      repeat (3) @(negedge slave_clk);
      slave_reset_n = 1'b1;
      #1;

      test_reset();
      test_register_rw();
      test_two_frames();
      test_zero_durations();
      test_random_frames();
      test_midframe_change();
      test_abort();
      test_mask_err();
      test_reset_during_dlp();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
